// File: rtl/riscv_ex_sched.sv
// rtl/riscv_ex_sched.sv - EX-stage issue scheduler: load-use stall detection and forwarding selects
module riscv_ex_sched #(
  parameter int XLEN = 32,
  parameter int REGN = 32,
  localparam int REGA = $clog2(REGN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [REGA-1:0] id_rs1,
  input  logic [REGA-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGA-1:0] id_rd,
  input  logic            id_is_load,
  input  logic            flush,
  output logic            ex_issue,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [15:0]     stall_cnt,
  output logic            busy
);

  if (XLEN < 1 || REGN < 2) begin : g_param_check
    $error("riscv_ex_sched: XLEN must be >= 1 and REGN >= 2");
  end

  typedef struct packed {
    logic            valid;
    logic [REGA-1:0] rd;
    logic            is_load;
  } slot_t;

  slot_t       s1_q, s2_q, s3_q, s1_d;
  logic [1:0]  fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
  logic [15:0] stall_q, stall_d;
  logic        busy_q;
  logic        s1_wr, s2_wr, s3_wr;
  logic [2:0]  hit_a, hit_b;
  logic        hazard;

  // rd=0 targets x0 and never produces a forwardable value
  assign s1_wr = s1_q.valid && (s1_q.rd != '0);
  assign s2_wr = s2_q.valid && (s2_q.rd != '0);
  assign s3_wr = s3_q.valid && (s3_q.rd != '0);

  assign hit_a = {s3_wr && (s3_q.rd == id_rs1), s2_wr && (s2_q.rd == id_rs1), s1_wr && (s1_q.rd == id_rs1)};
  assign hit_b = {s3_wr && (s3_q.rd == id_rs2), s2_wr && (s2_q.rd == id_rs2), s1_wr && (s1_q.rd == id_rs2)};

  always_comb begin
    hazard = 1'b0;
    if (s1_q.is_load) begin
      hazard = (id_use_rs1 && hit_a[0]) || (id_use_rs2 && hit_b[0]);
    end
  end

  assign id_ready = !hazard && !flush && rst_n;
  assign ex_issue = id_valid && id_ready;

  // Youngest producer wins: EX result beats MEM beats WB
  function automatic logic [1:0] pick_src(input logic use_rs, input logic [2:0] hit);
    if (!use_rs) return 2'd0;
    if (hit[0])  return 2'd1;
    if (hit[1])  return 2'd2;
    if (hit[2])  return 2'd3;
    return 2'd0;
  endfunction

  always_comb begin
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    s1_d    = '0;
    if (ex_issue) begin
      fwd_a_d      = pick_src(id_use_rs1, hit_a);
      fwd_b_d      = pick_src(id_use_rs2, hit_b);
      s1_d.valid   = 1'b1;
      s1_d.rd      = id_rd;
      s1_d.is_load = id_is_load;
    end
  end

  // Flush outranks a simultaneous hazard, so such a cycle is not a stall
  always_comb begin
    stall_d = stall_q;
    if (id_valid && hazard && !flush && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      fwd_a_q <= 2'd0;
      fwd_b_q <= 2'd0;
      stall_q <= 16'd0;
      busy_q  <= 1'b0;
    end else begin
      s3_q    <= s2_q;
      s2_q    <= s1_q;
      s1_q    <= s1_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      stall_q <= stall_d;
      busy_q  <= s1_d.valid || s1_q.valid || s2_q.valid;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign stall_cnt = stall_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_riscv_ex_sched.sv
// tb/tb_riscv_ex_sched.sv - directed and randomized bench for riscv_ex_sched against an issue-history model
module tb_riscv_ex_sched;
  localparam int REGA = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            id_valid = 1'b0;
  logic            id_ready;
  logic [REGA-1:0] id_rs1 = '0;
  logic [REGA-1:0] id_rs2 = '0;
  logic            id_use_rs1 = 1'b0;
  logic            id_use_rs2 = 1'b0;
  logic [REGA-1:0] id_rd = '0;
  logic            id_is_load = 1'b0;
  logic            flush = 1'b0;
  logic            ex_issue;
  logic [1:0]      fwd_a, fwd_b;
  logic [15:0]     stall_cnt;
  logic            busy;

  riscv_ex_sched dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_is_load(id_is_load), .flush(flush), .ex_issue(ex_issue),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit v;
    int rd;
    bit ld;
  } rec_t;

  // hist[k] is what was issued k+1 cycles ago
  rec_t hist[$];
  int   exp_fa = 0, exp_fb = 0, exp_stall = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writes(input rec_t r);
    return r.v && (r.rd != 0);
  endfunction

  function automatic int src_of(input bit use_rs, input int rs);
    if (!use_rs) return 0;
    for (int k = 0; k < 3; k++) begin
      if (writes(hist[k]) && hist[k].rd == rs) return k + 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    rec_t empty;
    empty = '{0, 0, 0};
    hist = {empty, empty, empty};
    exp_fa = 0;
    exp_fb = 0;
    exp_stall = 0;
  endtask

  task automatic step(input bit v, input int rs1, input int rs2, input bit u1, input bit u2,
                      input int rd, input bit ld, input bit fl);
    bit   hz, rdy, iss;
    rec_t r;
    id_valid = v; id_rs1 = REGA'(rs1); id_rs2 = REGA'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_rd = REGA'(rd); id_is_load = ld; flush = fl;
    #1;
    hz  = writes(hist[0]) && hist[0].ld && ((u1 && hist[0].rd == rs1) || (u2 && hist[0].rd == rs2));
    rdy = !hz && !fl;
    iss = v && rdy;
    chk("id_ready", id_ready, rdy);
    chk("ex_issue", ex_issue, iss);
    if (iss) begin
      exp_fa = src_of(u1, rs1);
      exp_fb = src_of(u2, rs2);
    end
    if (v && hz && !fl && exp_stall < 65535) exp_stall++;
    r = '{iss, rd, ld};
    hist.push_front(r);
    hist.delete(3);
    @(posedge clk);
    #1;
    chk("fwd_a", fwd_a, exp_fa);
    chk("fwd_b", fwd_b, exp_fb);
    chk("stall_cnt", stall_cnt, exp_stall);
    chk("busy", busy, hist[0].v || hist[1].v || hist[2].v);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int s0;

  initial begin
    model_reset();
    // reset state, with a request pending that must not be accepted
    id_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_ready", id_ready, 0);
    chk("rst_ex_issue", ex_issue, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_fwd_b", fwd_b, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;
    idle();

    // ALU to ALU forwarding
    step(1, 0, 0, 0, 0, 5, 0, 0);
    step(1, 5, 0, 1, 0, 1, 0, 0);
    chk("s1_fwd_a_ex", fwd_a, 1);

    // load-use: exactly one stall, then MEM forwarding
    s0 = exp_stall;
    step(1, 0, 0, 0, 0, 7, 1, 0);
    step(1, 0, 7, 0, 1, 2, 0, 0);
    chk("s2_stall_once", stall_cnt, 16'(s0 + 1));
    step(1, 0, 7, 0, 1, 2, 0, 0);
    chk("s2_fwd_b_mem", fwd_b, 2);

    // x0 never forwards; distance 3 gives WB; youngest producer wins
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 6, 0, 0);
    chk("s3_x0", fwd_a, 0);
    step(1, 0, 0, 0, 0, 3, 0, 0);
    idle();
    idle();
    step(1, 3, 0, 1, 0, 8, 0, 0);
    chk("s3_wb", fwd_a, 3);
    step(1, 0, 0, 0, 0, 3, 0, 0);
    step(1, 0, 0, 0, 0, 3, 0, 0);
    step(1, 3, 0, 1, 0, 8, 0, 0);
    chk("s3_youngest", fwd_a, 1);

    // flush outranks the hazard and is not counted
    s0 = exp_stall;
    step(1, 0, 0, 0, 0, 9, 1, 0);
    step(1, 9, 0, 1, 0, 4, 0, 1);
    chk("s4_no_count", stall_cnt, 16'(s0));
    step(1, 9, 0, 1, 0, 4, 0, 0);
    chk("s4_fwd_a_mem", fwd_a, 2);

    // asynchronous reset with work in flight
    step(1, 0, 0, 0, 0, 11, 0, 0);
    step(1, 0, 0, 0, 0, 12, 1, 0);
    step(1, 11, 12, 1, 1, 13, 0, 0);
    id_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("s5_busy", busy, 0);
    chk("s5_fwd_a", fwd_a, 0);
    chk("s5_fwd_b", fwd_b, 0);
    chk("s5_stall", stall_cnt, 0);
    chk("s5_id_ready", id_ready, 0);
    chk("s5_ex_issue", ex_issue, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 13, 11, 1, 1, 0, 0, 0);
    chk("s5_after_fwd_a", fwd_a, 0);

    // randomized traffic over a small register window to force collisions
    repeat (400) begin
      step($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0),
           $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(7, 0),
           $urandom_range(2, 0) == 0, $urandom_range(7, 0) == 0);
    end

    // saturation: preload the counter near the top, then drive real load-use stalls
    force dut.stall_q = 16'hFFFD;
    exp_stall = 16'hFFFD;
    idle();
    release dut.stall_q;
    #1;
    chk("s6_preload", stall_cnt, 16'hFFFD);
    repeat (4) begin
      step(1, 0, 0, 0, 0, 7, 1, 0);
      step(1, 7, 0, 1, 0, 7, 1, 0);
    end
    chk("s6_saturated", stall_cnt, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
